// File: rtl/fir_stream_sched_pkg.sv
// Shared types and constants for the FIR streamer tile scheduler.
package fir_stream_sched_pkg;

    localparam int SCHED_AW   = 32;
    localparam int SCHED_LW   = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        START_B,
        START_A,
        WAIT,
        NEXT,
        FINISH
    } sched_state_e;

    typedef struct packed {
        logic [SCHED_AW-1:0] base_a;
        logic [SCHED_AW-1:0] base_b;
        logic [SCHED_LW-1:0] tile_len;
        logic [SCHED_LW-1:0] n_tiles;
    } sched_cfg_t;

endpackage

// File: rtl/fir_sched_addr_gen.sv
// Holds the per-job tile addresses, tile length and tile counter; the FSM
// only decides when to load a new job or advance to the next tile.
module fir_sched_addr_gen
    import fir_stream_sched_pkg::*;
#(
    parameter int AW           = 32,
    parameter int LW           = 16,
    parameter int STRIDE_BYTES = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          advance_i,
    input  sched_cfg_t    cfg_i,
    output logic [AW-1:0] a_addr_o,
    output logic [AW-1:0] b_addr_o,
    output logic [LW-1:0] size_o,
    output logic [LW-1:0] tile_idx_o,
    output logic          last_tile_o
);

    logic [AW-1:0] aAddr_q, aAddr_d;
    logic [AW-1:0] bAddr_q, bAddr_d;
    logic [LW-1:0] tileLen_q, tileLen_d;
    logic [LW-1:0] nTiles_q, nTiles_d;
    logic [LW-1:0] tileIdx_q, tileIdx_d;
    logic [AW-1:0] stride;

    // Byte stride between tiles, deliberately truncated to AW bits so
    // addresses wrap silently.
    assign stride = AW'(tileLen_q) * AW'(STRIDE_BYTES);

    always_comb begin
        aAddr_d   = aAddr_q;
        bAddr_d   = bAddr_q;
        tileLen_d = tileLen_q;
        nTiles_d  = nTiles_q;
        tileIdx_d = tileIdx_q;
        if (load_i) begin
            aAddr_d   = AW'(cfg_i.base_a);
            bAddr_d   = AW'(cfg_i.base_b);
            tileLen_d = LW'(cfg_i.tile_len);
            nTiles_d  = LW'(cfg_i.n_tiles);
            tileIdx_d = '0;
        end else if (advance_i) begin
            aAddr_d   = aAddr_q + stride;
            bAddr_d   = bAddr_q + stride;
            tileIdx_d = tileIdx_q + LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aAddr_q   <= '0;
            bAddr_q   <= '0;
            tileLen_q <= '0;
            nTiles_q  <= '0;
            tileIdx_q <= '0;
        end else begin
            aAddr_q   <= aAddr_d;
            bAddr_q   <= bAddr_d;
            tileLen_q <= tileLen_d;
            nTiles_q  <= nTiles_d;
            tileIdx_q <= tileIdx_d;
        end
    end

    assign a_addr_o    = aAddr_q;
    assign b_addr_o    = bAddr_q;
    assign size_o      = tileLen_q;
    assign tile_idx_o  = tileIdx_q;
    assign last_tile_o = ((tileIdx_q + LW'(1)) == nTiles_q);

endmodule

// File: rtl/fir_stream_sched.sv
// Tile scheduler: splits a FIR job into tiles and sequences sink-then-source
// starts for each tile, waiting for both done pulses before advancing.
module fir_stream_sched #(
    parameter int AW         = 32,
    parameter int LW         = 16,
    parameter int WORD_BYTES = fir_stream_sched_pkg::WORD_BYTES
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_a_i,
    input  logic [AW-1:0] base_b_i,
    input  logic [LW-1:0] tile_len_i,
    input  logic [LW-1:0] n_tiles_i,
    input  logic          a_ready_start_i,
    input  logic          a_done_i,
    input  logic          b_ready_start_i,
    input  logic          b_done_i,
    output logic          a_req_start_o,
    output logic [AW-1:0] a_addr_o,
    output logic [LW-1:0] a_size_o,
    output logic          b_req_start_o,
    output logic [AW-1:0] b_addr_o,
    output logic [LW-1:0] b_size_o,
    output logic [LW-1:0] tile_idx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    import fir_stream_sched_pkg::*;

    sched_state_e state_q, state_d;
    logic         err_q, err_d;
    logic         aDone_q, aDone_d;
    logic         bDone_q, bDone_d;
    logic         rstAny;
    logic         cfgZero;
    logic         loadCfg;
    logic         advanceTile;
    logic         lastTile;
    logic [LW-1:0] tileSize;
    sched_cfg_t   cfgIn;

    assign rstAny  = rst_i | clear_i;
    assign cfgZero = (tile_len_i == '0) || (n_tiles_i == '0);

    always_comb begin
        cfgIn          = '0;
        cfgIn.base_a   = SCHED_AW'(base_a_i);
        cfgIn.base_b   = SCHED_AW'(base_b_i);
        cfgIn.tile_len = SCHED_LW'(tile_len_i);
        cfgIn.n_tiles  = SCHED_LW'(n_tiles_i);
    end

    fir_sched_addr_gen #(
        .AW           (AW),
        .LW           (LW),
        .STRIDE_BYTES (WORD_BYTES)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rstAny),
        .load_i      (loadCfg),
        .advance_i   (advanceTile),
        .cfg_i       (cfgIn),
        .a_addr_o    (a_addr_o),
        .b_addr_o    (b_addr_o),
        .size_o      (tileSize),
        .tile_idx_o  (tile_idx_o),
        .last_tile_o (lastTile)
    );

    // Start requests follow ready combinationally so a request is never
    // presented while the streamer cannot take it.
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        aDone_d       = aDone_q;
        bDone_d       = bDone_q;
        loadCfg       = 1'b0;
        advanceTile   = 1'b0;
        a_req_start_o = 1'b0;
        b_req_start_o = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    loadCfg = 1'b1;
                    err_d   = cfgZero;
                    aDone_d = 1'b0;
                    bDone_d = 1'b0;
                    state_d = cfgZero ? FINISH : START_B;
                end
            end
            START_B: begin
                b_req_start_o = b_ready_start_i;
                if (b_ready_start_i) begin
                    state_d = START_A;
                end
            end
            START_A: begin
                a_req_start_o = a_ready_start_i;
                aDone_d       = aDone_q | a_done_i;
                bDone_d       = bDone_q | b_done_i;
                if (a_ready_start_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                aDone_d = aDone_q | a_done_i;
                bDone_d = bDone_q | b_done_i;
                if (aDone_d && bDone_d) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                advanceTile = 1'b1;
                aDone_d     = 1'b0;
                bDone_d     = 1'b0;
                state_d     = lastTile ? FINISH : START_B;
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rstAny) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            aDone_q <= 1'b0;
            bDone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            aDone_q <= aDone_d;
            bDone_q <= bDone_d;
        end
    end

    assign a_size_o = tileSize;
    assign b_size_o = tileSize;
    assign busy_o   = (state_q != IDLE);
    assign err_o    = err_q;

endmodule
